// File: rtl/window_deserializer.sv
// Reassembles serializer beats into one HOG window plus pyramid metadata,
// flagging metadata drift across beats and non-zero padding in the last beat.
module window_deserializer #(
  parameter int WINDOW_WIDTH = 1152,
  parameter int BUS_WIDTH    = 128,
  parameter int META_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stream_valid,
  output logic                    stream_ready,
  input  logic [BUS_WIDTH-1:0]    stream,
  output logic                    window_valid,
  input  logic                    window_ready,
  output logic [WINDOW_WIDTH-1:0] window,
  output logic [META_WIDTH-1:0]   metadata,
  output logic                    meta_error,
  output logic                    pad_error
);

  localparam int DATA_W    = BUS_WIDTH - META_WIDTH;
  localparam int REMAIN    = WINDOW_WIDTH % DATA_W;
  localparam int NUM_BEATS = WINDOW_WIDTH / DATA_W + 1;
  localparam int CNT_W     = $clog2(NUM_BEATS);
  localparam int TAIL_LSB  = (NUM_BEATS - 1) * DATA_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  typedef enum logic {COLLECT, HOLD} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [WINDOW_WIDTH-1:0] window_q, window_d;
  logic [META_WIDTH-1:0]   metadata_q, metadata_d;
  logic                    meta_error_q, meta_error_d;
  logic                    pad_error_q, pad_error_d;

  logic [META_WIDTH-1:0]   beat_meta;
  logic [DATA_W-1:0]       beat_data;
  logic                    pad_nonzero;

  assign beat_meta   = stream[BUS_WIDTH-1 -: META_WIDTH];
  assign beat_data   = stream[DATA_W-1:0];
  assign pad_nonzero = |beat_data[DATA_W-1:REMAIN];

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    window_d     = window_q;
    metadata_d   = metadata_q;
    meta_error_d = meta_error_q;
    pad_error_d  = pad_error_q;
    case (state_q)
      COLLECT: begin
        if (stream_valid) begin
          for (int k = 0; k < NUM_BEATS - 1; k++) begin
            if (beat_cnt_q == CNT_W'(k)) window_d[k*DATA_W +: DATA_W] = beat_data;
          end
          // Beat 0 opens a new window: its metadata becomes the reference.
          if (beat_cnt_q == '0) begin
            metadata_d   = beat_meta;
            meta_error_d = 1'b0;
            pad_error_d  = 1'b0;
          end else begin
            meta_error_d = meta_error_q | (beat_meta != metadata_q);
          end
          if (beat_cnt_q == LAST_BEAT) begin
            window_d[TAIL_LSB +: REMAIN] = beat_data[REMAIN-1:0];
            pad_error_d = pad_nonzero;
            beat_cnt_d  = '0;
            state_d     = HOLD;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (window_ready) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= COLLECT;
      beat_cnt_q   <= '0;
      window_q     <= '0;
      metadata_q   <= '0;
      meta_error_q <= 1'b0;
      pad_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      window_q     <= window_d;
      metadata_q   <= metadata_d;
      meta_error_q <= meta_error_d;
      pad_error_q  <= pad_error_d;
    end
  end

  assign stream_ready = (state_q == COLLECT);
  assign window_valid = (state_q == HOLD);
  assign window       = window_q;
  assign metadata     = metadata_q;
  assign meta_error   = meta_error_q;
  assign pad_error    = pad_error_q;

endmodule

// File: doc/window_deserializer.md
# window_deserializer

Reassembles the beat stream produced by the window serializer back into one full HOG detection window plus its pyramid-level metadata. It sits directly downstream of the serializer, on the consumer side of the 128-bit link, and presents complete windows to the classifier through a valid/ready handshake. It also checks each window for metadata consistency across beats and for non-zero padding in the final beat.

## Interface
- WINDOW_WIDTH, 1152: reconstructed window width in bits.
- BUS_WIDTH, 128: stream beat width.
- META_WIDTH, 4: metadata field width, carried in the top bits of every beat.
- Derived: DATA_W = BUS_WIDTH-META_WIDTH (124). REMAIN = WINDOW_WIDTH % DATA_W (36). NUM_BEATS = WINDOW_WIDTH/DATA_W + 1 (10). REMAIN must be non-zero.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stream_valid  in  1  upstream beat valid.
- stream_ready  out  1  beat accepted when stream_valid && stream_ready.
- stream  in  BUS_WIDTH  beat: [BUS_WIDTH-1 -: META_WIDTH] = metadata, [DATA_W-1:0] = data.
- window_valid  out  1  a complete window is held.
- window_ready  in  1  downstream accepts the window when window_valid && window_ready.
- window  out  WINDOW_WIDTH  reassembled window.
- metadata  out  META_WIDTH  metadata captured from beat 0.
- meta_error  out  1  a later beat's metadata differed from beat 0. Valid with window_valid.
- pad_error  out  1  last beat had non-zero bits in data[DATA_W-1:REMAIN]. Valid with window_valid.

## Operation
- Beat counter beat_cnt counts 0..NUM_BEATS-1 and increments on each accepted beat.
- Beat k (k < NUM_BEATS-1) is written to window[k*DATA_W +: DATA_W].
- The last beat writes stream[REMAIN-1:0] to window[(NUM_BEATS-1)*DATA_W +: REMAIN].
- Beat 0: metadata is loaded from the beat, and meta_error and pad_error are cleared.
- Beats 1..NUM_BEATS-1: meta_error is set if the beat's metadata differs from the stored metadata. Once set, it stays set until the next beat 0.
- Last beat: pad_error is set if any padding bit is 1. beat_cnt wraps to 0 and window_valid is set.
- States:
  - COLLECT (window_valid=0): stream_ready=1.
  - HOLD (window_valid=1): stream_ready=0.
- Transitions:
  - COLLECT→HOLD on acceptance of the last beat.
  - HOLD→COLLECT on window_valid && window_ready.
- Outputs are stable throughout HOLD. window, metadata and the error flags change only on accepted beats.
- Error flags do not block delivery. The window is always presented, with its flags attached.
- stream_ready is the registered state, not combinationally dependent on window_ready. There is no same-cycle pass-through.
- Reset, including mid-window: beat_cnt=0 and state=COLLECT. The partial window is discarded, and the next accepted beat is treated as beat 0.

## Timing
- Reset values: stream_ready=1, window_valid=0, window=0, metadata=0, meta_error=0, pad_error=0.
- window_valid rises on the clock edge that accepts the last beat, i.e. it is visible in the cycle after that beat.
- Minimum period is NUM_BEATS+1 cycles per window: 10 accept cycles plus 1 hold cycle when window_ready=1.
- Upstream bubbles (stream_valid=0) stall beat_cnt without loss.
- window_ready asserted while window_valid=0 is ignored.
- In the hold-release cycle stream_ready=0, so no beat is accepted. Collection resumes on the next cycle.

## Test plan
- Single window, no stalls:
  - Stimulus: window bit i = i%3==0; metadata 4'h5 on all 10 beats; zero padding; window_ready=1.
  - Required: window matches bit-exact; metadata=5; both error flags 0.
  - Required: window_valid is high for exactly 1 cycle, 10 cycles after the first beat accepted.
- Back-pressure:
  - Stimulus: window_ready=0 for 20 cycles after completion while upstream keeps stream_valid=1.
  - Required: stream_ready=0 and outputs stable for all 20 cycles. The second window's beat 0 is accepted only in the cycle after the handshake, and the second window is reassembled correctly.
- Upstream bubbles: stream_valid toggling 1,0,0,1,… across a window -> window is reassembled identically to the no-stall case.
- Metadata mismatch: beats carry 4'h3 except beat 6 = 4'h7 -> meta_error=1 and metadata=3. On the next clean window, meta_error=0.
- Padding error: last beat with stream[40]=1 -> pad_error=1, meta_error=0, and window[1151:1116] equals the beat's bits [35:0].
- Reset mid-window: assert rst after 4 beats, then send a full 10-beat window.
  - Required: all outputs return to reset values.
  - Required: the new window is reassembled with no contamination from the aborted beats.
